// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue.
// slave is the queue side; master is the fetch/decode side.
interface fetch_queue_if #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] in_pc_i;
  logic [XLEN-1:0] in_instr_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  logic [XLEN-1:0] out_instr_o;
  logic [CW-1:0]   count_o;

  modport slave (
    input  flush_i, in_valid_i, in_pc_i, in_instr_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_instr_o, count_o
  );

  modport master (
    output flush_i, in_valid_i, in_pc_i, in_instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_instr_o, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular {pc, instr} FIFO between fetch and decode. No fall-through:
// outputs come only from registered state; flush empties on the next edge.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  fetch_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               in_ready, out_valid, push, pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = q.in_valid_i  && in_ready  && !q.flush_i;
  assign pop       = q.out_ready_i && out_valid && !q.flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (q.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally unreset; validity is tracked by count alone.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{pc: q.in_pc_i, instr: q.in_instr_i};
  end

  assign q.in_ready_o  = in_ready;
  assign q.out_valid_o = out_valid;
  assign q.out_pc_o    = out_valid ? mem[rd_ptr].pc    : '0;
  assign q.out_instr_o = out_valid ? mem[rd_ptr].instr : NOP;
  assign q.count_o     = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (DEPTH=2): expected entries are queued
// when the model accepts a push and compared when the head is consumed.
module tb_fetch_queue;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] sb[$];

  fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .q      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  // Advances one edge and applies the reference behaviour to the scoreboard.
  task automatic tick();
    logic do_push, do_pop;
    do_push = bus.in_valid_i && (sb.size() < DEPTH) && !bus.flush_i;
    do_pop  = bus.out_ready_i && (sb.size() > 0) && !bus.flush_i;
    @(posedge clk);
    if (rst_n) begin
      if (bus.flush_i) sb.delete();
      else begin
        if (do_pop)  void'(sb.pop_front());
        if (do_push) sb.push_back({bus.in_pc_i, bus.in_instr_i});
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush_i = 0; bus.in_valid_i = 0; bus.out_ready_i = 0;
    bus.in_pc_i = '0; bus.in_instr_i = '0;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] ins);
    bus.in_valid_i = 1; bus.in_pc_i = pc; bus.in_instr_i = ins;
    tick();
    bus.in_valid_i = 0;
  endtask

  task automatic drain();
    bus.out_ready_i = 1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    bus.out_ready_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid_o); end
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready_o); end
    total++; if (bus.count_o !== 2'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", bus.count_o); end
    total++; if (bus.out_instr_o !== NOP) begin bad++; $display("FAIL rst_instr: got %h want %h", bus.out_instr_o, NOP); end
    total++; if (bus.out_pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", bus.out_pc_o); end
    rst_n = 1;
    push_one(32'h0, 32'h0050_0093);
    total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", bus.out_valid_o); end
    total++; if (bus.out_instr_o !== 32'h0050_0093) begin bad++; $display("FAIL first_instr: got %h want 00500093", bus.out_instr_o); end
    drain();
  endtask

  task automatic test_fill_drain();
    logic [63:0] exp;
    push_one(32'h0, $urandom);
    push_one(32'h4, $urandom);
    total++; if (bus.count_o !== 2'd2) begin bad++; $display("FAIL fill_count: got %0d want 2", bus.count_o); end
    total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready: got %b want 0", bus.in_ready_o); end
    bus.in_valid_i = 1; bus.in_pc_i = 32'h8; bus.in_instr_i = $urandom;
    tick(); tick();
    total++; if (bus.count_o !== 2'(sb.size())) begin bad++; $display("FAIL held_push_count: got %0d want %0d", bus.count_o, sb.size()); end
    bus.in_valid_i = 0;
    bus.out_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (sb.size() == 0) begin
        if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL drain_empty: got valid %b want 0", bus.out_valid_o); end
      end else begin
        exp = sb[0];
        if (bus.out_valid_o !== 1'b1 || {bus.out_pc_o, bus.out_instr_o} !== exp)
          begin bad++; $display("FAIL drain_head%0d: got %b %h want 1 %h", i, bus.out_valid_o, {bus.out_pc_o, bus.out_instr_o}, exp); end
      end
      tick();
    end
    bus.out_ready_i = 0;
  endtask

  task automatic test_streaming();
    logic [63:0] exp;
    bus.out_ready_i = 1;
    for (int i = 0; i <= 8; i++) begin
      bus.in_valid_i = (i < 8);
      bus.in_pc_i    = 32'(i * 4);
      bus.in_instr_i = $urandom;
      if (i > 0) begin
        exp = sb[0];
        total++;
        if (bus.out_valid_o !== 1'b1 || {bus.out_pc_o, bus.out_instr_o} !== exp)
          begin bad++; $display("FAIL stream_head%0d: got %b %h want 1 %h", i, bus.out_valid_o, {bus.out_pc_o, bus.out_instr_o}, exp); end
        total++; if (bus.count_o !== 2'd1) begin bad++; $display("FAIL stream_count%0d: got %0d want 1", i, bus.count_o); end
      end
      tick();
    end
    idle_inputs();
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL stream_end: got valid %b want 0", bus.out_valid_o); end
  endtask

  task automatic test_flush();
    logic [63:0] exp;
    push_one(32'h10, $urandom);
    push_one(32'h14, $urandom);
    bus.flush_i = 1; bus.in_valid_i = 1; bus.out_ready_i = 1;
    bus.in_pc_i = 32'h40; bus.in_instr_i = $urandom;
    tick();
    idle_inputs();
    total++; if (bus.count_o !== 2'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", bus.count_o); end
    total++; if (bus.out_valid_o !== 1'b0 || bus.out_pc_o !== 32'h0 || bus.out_instr_o !== NOP)
      begin bad++; $display("FAIL flush_outputs: got %b %h %h want 0 0 %h", bus.out_valid_o, bus.out_pc_o, bus.out_instr_o, NOP); end
    push_one(32'h44, 32'h0020_0113);
    exp = sb[0];
    total++; if ({bus.out_pc_o, bus.out_instr_o} !== exp || bus.count_o !== 2'd1)
      begin bad++; $display("FAIL flush_after: got %h cnt %0d want %h cnt 1", {bus.out_pc_o, bus.out_instr_o}, bus.count_o, exp); end
    drain();
  endtask

  task automatic test_reset_mid();
    push_one(32'h20, $urandom);
    push_one(32'h24, $urandom);
    #1 rst_n = 0;
    #1;
    total++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.count_o !== 2'd0 ||
                 bus.out_pc_o !== 32'h0 || bus.out_instr_o !== NOP)
      begin bad++; $display("FAIL midrst_outputs: got v%b r%b c%0d %h %h", bus.out_valid_o, bus.in_ready_o, bus.count_o, bus.out_pc_o, bus.out_instr_o); end
    sb.delete();
    #1 rst_n = 1;
    push_one(32'h80, 32'h0030_0193);
    total++; if (bus.count_o !== 2'd1 || bus.out_pc_o !== 32'h80 || bus.out_instr_o !== 32'h0030_0193)
      begin bad++; $display("FAIL midrst_push: got c%0d %h %h want c1 00000080 00300193", bus.count_o, bus.out_pc_o, bus.out_instr_o); end
    drain();
  endtask

  task automatic test_full_pop();
    logic [63:0] exp;
    push_one(32'h30, $urandom);
    push_one(32'h34, $urandom);
    bus.out_ready_i = 1; bus.in_valid_i = 1;
    bus.in_pc_i = 32'h100; bus.in_instr_i = $urandom;
    exp = sb[0];
    total++; if ({bus.out_pc_o, bus.out_instr_o} !== exp) begin bad++; $display("FAIL fullpop_head: got %h want %h", {bus.out_pc_o, bus.out_instr_o}, exp); end
    tick();
    total++; if (bus.count_o !== 2'(DEPTH - 1)) begin bad++; $display("FAIL fullpop_count: got %0d want %0d", bus.count_o, DEPTH - 1); end
    exp = sb[0];
    total++; if (bus.out_pc_o !== 32'h34 || {bus.out_pc_o, bus.out_instr_o} !== exp)
      begin bad++; $display("FAIL fullpop_next: got %h want %h", {bus.out_pc_o, bus.out_instr_o}, exp); end
    tick();
    bus.in_valid_i = 0;
    exp = sb[0];
    total++; if (bus.out_pc_o !== 32'h100 || {bus.out_pc_o, bus.out_instr_o} !== exp || bus.count_o !== 2'd1)
      begin bad++; $display("FAIL fullpop_accept: got %h c%0d want %h c1", {bus.out_pc_o, bus.out_instr_o}, bus.count_o, exp); end
    drain();
    total++; if (bus.count_o !== 2'd0) begin bad++; $display("FAIL fullpop_empty: got %0d want 0", bus.count_o); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_flush();
    test_reset_mid();
    test_full_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the instruction-memory fetch stage and the decode stage. It buffers fetched `{pc, instr}` pairs in a small circular FIFO and presents the oldest entry to decode. Decode slices `out_instr_o[31:7]` for immediate extension and `[6:0]`/funct fields for control. Valid/ready handshakes on both sides decouple fetch stalls from decode stalls, and a flush input discards all buffered entries on branch or jump redirect.

## Interface
- `DEPTH`, default 2: number of entries. Must be a power of two, ≥ 2.
- `XLEN`, default 32: width of the PC and instruction fields.
- `clk_i`  in  1  system clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `flush_i`  in  1  discard all entries; has priority over push and pop.
- `in_valid_i`  in  1  fetch presents a valid entry.
- `in_ready_o`  out  1  queue accepts an entry this cycle.
- `in_pc_i`  in  XLEN  PC of the fetched instruction.
- `in_instr_i`  in  XLEN  fetched instruction word.
- `out_valid_o`  out  1  head entry is valid.
- `out_ready_i`  in  1  decode consumes the head this cycle.
- `out_pc_o`  out  XLEN  head PC; 0 when `out_valid_o`=0.
- `out_instr_o`  out  XLEN  head instruction; 32'h00000013 (NOP) when `out_valid_o`=0.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- **Storage:** DEPTH-entry array of {pc, instr}, with write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits. Pointers wrap naturally modulo DEPTH. `count` is a separate register.
- **Push:** occurs when `in_valid_i && in_ready_o && !flush_i`. The entry is written at `wr_ptr`, and `wr_ptr` increments.
- **Pop:** occurs when `out_valid_o && out_ready_i && !flush_i`. `rd_ptr` increments.
- **Count update:** +1 on push only, −1 on pop only, unchanged when both or neither occur.
- **Ready/valid:** `in_ready_o` = (count != DEPTH). `out_valid_o` = (count != 0). Both are decoded combinationally from registered state only, with no combinational path from `in_valid_i` or `out_ready_i`.
- **No fall-through:** an entry pushed in cycle N is first visible on the outputs in cycle N+1.
- **Full:** `in_ready_o`=0, so no push is accepted even if a pop occurs the same cycle. Fetch must hold `in_valid_i` and its data until ready.
- **Empty:** `out_valid_o`=0, so no pop occurs, and the outputs are forced to PC 0 / NOP.
- **Flush:** on the next edge, `count`, `wr_ptr` and `rd_ptr` clear to 0. Any push or pop in the flush cycle is ignored. Array contents are not cleared (don't-care).
- **Reset (asserted any time, including mid-transfer):** immediately forces `count`=0 and both pointers to 0. As a result, `out_valid_o`=0, `in_ready_o`=1, `out_pc_o`=0, `out_instr_o`=32'h00000013 and `count_o`=0. Array contents are not reset.
- **Output mux:** `out_pc_o`/`out_instr_o` are read from the array at `rd_ptr`, gated by `out_valid_o`.
- **Data integrity:** entries are never reordered, duplicated, or dropped except by flush or reset.

## Timing
- Latency from push to output is 1 cycle.
- Sustained throughput is 1 entry/cycle when push and pop occur together at 0 < count < DEPTH.
- All outputs depend only on registered state, with no input-to-output combinational path.
- Reset takes effect asynchronously, and release is synchronous to `clk_i`. The first push can be accepted on the first rising edge after deassertion.
- `in_valid_i` held while `in_ready_o`=0 must not corrupt state.
- Flush and reset each take effect within one edge, leaving the queue in the empty state described under Operation.

## Test plan
- **Reset values:** hold `rst_ni`=0 → `out_valid_o`=0, `in_ready_o`=1, `count_o`=0, `out_instr_o`=32'h00000013, `out_pc_o`=0. Release, then push {0x0, 0x00500093} → next cycle `out_valid_o`=1, `out_instr_o`=0x00500093.
- **Fill and drain:** with `out_ready_i`=0, push PCs 0x0 and 0x4 (DEPTH=2) → `count_o`=2, `in_ready_o`=0. A third push with `in_valid_i` held is not accepted. Raise `out_ready_i` → outputs show 0x0 then 0x4, then `out_valid_o`=0.
- **Streaming:** push 8 sequential PCs 0x0..0x1C with `out_ready_i`=1 throughout → outputs appear in order one per cycle after a 1-cycle latency. Pointers wrap without loss and `count_o` stays at 1.
- **Flush with push:** with `count_o`=2, assert `flush_i` together with `in_valid_i` (PC 0x40) and `out_ready_i` → next cycle `count_o`=0 and `out_valid_o`=0. PC 0x40 is absent, and no entry was consumed.
- **Reset mid-operation:** with `count_o`=2, pulse `rst_ni` low between clock edges → outputs immediately go to their reset values. After release, a push of PC 0x80 appears as the sole entry.
- **Full with pop:** at `count_o`=DEPTH, drive `out_ready_i`=1 and `in_valid_i`=1 → the pop happens and the push is refused that cycle (`count_o`=DEPTH−1). The push is accepted the following cycle.
